// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, exception bit
// positions, the controller state encoding and a one-hot helper.
package fpu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_CVT = 4'b1000;

   localparam int EXC_INVALID   = 4;
   localparam int EXC_DIVZERO   = 3;
   localparam int EXC_OVERFLOW  = 2;
   localparam int EXC_UNDERFLOW = 1;
   localparam int EXC_INEXACT   = 0;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fpu_state_e;

   function automatic logic is_onehot4(input logic [3:0] op);
      return (op != 4'b0000) && ((op & (op - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter tracking remaining execution-unit latency.
// zero_next flags the final cycle: the next decrement reaches zero.
module fpu_lat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero_next
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero_next = (count == W'(1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller: accepts one FPU request, pulses the
// matching unit enable, waits out its latency and holds the captured result.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = 1,
   parameter int LAT_MUL = 2,
   parameter int LAT_CVT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic [3:0]  ena,
   output logic [15:0] float_a,
   output logic [15:0] float_b,
   input  logic [31:0] res_data,
   input  logic [4:0]  res_exc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_exc,
   output logic [4:0]  sticky_exc,
   input  logic        clr_sticky,
   output fpu_state_e  dbg_state
);

   fpu_state_e       state;
   logic [CNT_W-1:0] lat_sel;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero_next;
   logic             out_hs;

   // Handshake: a transfer happens on any cycle where valid and ready are
   // both high; valid never depends on ready, and only IDLE/HOLD offer them.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign out_hs    = out_valid && out_ready;
   assign dbg_state = state;

   // ena still carries the latched opcode during ISSUE, so it selects latency.
   always_comb begin
      lat_sel = CNT_W'(LAT_ADD);
      case (ena)
         OP_MUL:  lat_sel = CNT_W'(LAT_MUL);
         OP_CVT:  lat_sel = CNT_W'(LAT_CVT);
         default: lat_sel = CNT_W'(LAT_ADD);
      endcase
   end

   fpu_lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state == ISSUE),
      .load_val  (lat_sel),
      .dec       (state == WAIT),
      .count     (cnt),
      .zero_next (cnt_zero_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ena        <= '0;
         float_a    <= '0;
         float_b    <= '0;
         out_data   <= '0;
         out_exc    <= '0;
         sticky_exc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_onehot4(in_op)) begin
                     ena     <= in_op;
                     float_a <= in_a;
                     float_b <= in_b;
                     state   <= ISSUE;
                  end else begin
                     out_data             <= '0;
                     out_exc              <= '0;
                     out_exc[EXC_INVALID] <= 1'b1;
                     state                <= HOLD;
                  end
               end
            end
            ISSUE: begin
               ena   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt_zero_next) begin
                  out_data <= res_data;
                  out_exc  <= res_exc;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A clear that coincides with a handshake keeps only that result's flags.
         if (clr_sticky) begin
            sticky_exc <= out_hs ? out_exc : '0;
         end else if (out_hs) begin
            sticky_exc <= sticky_exc | out_exc;
         end
      end
   end

endmodule
